// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard and stall controller for the 5-stage core.
// Detects load-use hazards, applies EX-resolved redirects, freezes the pipe
// on data-memory wait, and defers redirects that arrive during a freeze.
// Keeps saturating counters for stall, flush and freeze cycles.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   id_valid, id_opcode,
//   id_rs1, id_rs2             instruction in ID
//   ex_memread, ex_rd          load destination in EX
//   ex_redirect                taken branch/jump pulse from EX
//   dmem_busy                  data memory not ready (level)
//   cnt_clear                  zero the performance counters
//   stall                      bubble request to the decode controller
//   pc_write, ifid_write       PC and IF/ID enables
//   pipe_hold                  freeze ID/EX, EX/MEM, MEM/WB
//   ifid_flush, idex_flush     clear IF/ID and ID/EX to NOP
//   redirect_take              PC mux selects the EX target
//   state                      FSM state (RUN=0, LOAD_STALL=1, FREEZE=2)
//   stall_cnt, flush_cnt,
//   freeze_cnt                 saturating performance counters
module hazard_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             dmem_busy,
  input  logic             cnt_clear,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             pipe_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             redirect_take,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FREEZE     = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   pend_q, pend_d;
  logic   uses_rs1, uses_rs2, hazard;

  // Which source fields the ID instruction actually reads
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_opcode)
      OP_LOAD, OP_IMM, OP_JALR: uses_rs1 = 1'b1;
      OP_STORE, OP_REG, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign hazard = id_valid & ex_memread & (ex_rd != 5'd0) &
                  ((uses_rs1 & (id_rs1 == ex_rd)) | (uses_rs2 & (id_rs2 == ex_rd)));

  // State and pending-redirect register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Next state and control outputs; priority freeze > redirect > load-use
  always_comb begin
    state_d       = RUN;
    pend_d        = pend_q;
    stall         = 1'b0;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    pipe_hold     = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    redirect_take = 1'b0;
    if (rst) begin
      stall      = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pend_d     = 1'b0;
    end else if (dmem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      pend_d     = pend_q | ex_redirect;
      state_d    = FREEZE;
    end else if (ex_redirect || pend_q) begin
      // pend_q can only be set on exit from FREEZE
      redirect_take = 1'b1;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      pend_d        = 1'b0;
    end else if (hazard && (state_q != LOAD_STALL)) begin
      // Masked in LOAD_STALL so each load inserts exactly one bubble
      stall      = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      state_d    = LOAD_STALL;
    end
  end

  assign state = state_q;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != CNT_MAX))       stall_cnt  <= stall_cnt + CNT_W'(1);
      if (idex_flush && (flush_cnt != CNT_MAX))  flush_cnt  <= flush_cnt + CNT_W'(1);
      if (pipe_hold && (freeze_cnt != CNT_MAX))  freeze_cnt <= freeze_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vector table, hand sequences for counter
// saturation/clear, and random stimulus against a behavioural model.
// A second instance with 4-bit counters exercises saturation cheaply.
module tb_hazard_unit;

  typedef struct packed {
    logic       rst;
    logic       v;
    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       mr;
    logic [4:0] rd;
    logic       redir;
    logic       busy;
    logic       clr;
  } in_t;

  typedef struct {
    in_t        i;
    logic [6:0] ctl;
    logic [1:0] st;
    logic       chk;
    int         sc, fc, zc;
  } vec_t;

  // {stall, pc_write, ifid_write, pipe_hold, ifid_flush, idex_flush, redirect_take}
  localparam logic [6:0] IDL  = 7'b0110000;
  localparam logic [6:0] STL  = 7'b1000000;
  localparam logic [6:0] FRZ  = 7'b0001000;
  localparam logic [6:0] RDR  = 7'b0110111;
  localparam logic [6:0] RSTP = 7'b1000110;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011;
  localparam logic [6:0] BR = 7'b1100011, IM = 7'b0010011, JR = 7'b1100111;
  localparam logic [6:0] JL = 7'b1101111, LU = 7'b0110111, AU = 7'b0010111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, ex_memread, ex_redirect, dmem_busy, cnt_clear;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, ex_rd;

  logic        stall, pc_write, ifid_write, pipe_hold, ifid_flush, idex_flush, redirect_take;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt, freeze_cnt;
  logic        s_stall, s_pc_write, s_ifid_write, s_pipe_hold, s_ifid_flush, s_idex_flush, s_redirect_take;
  logic [1:0]  s_state;
  logic [3:0]  s_stall_cnt, s_flush_cnt, s_freeze_cnt;

  hazard_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .dmem_busy(dmem_busy), .cnt_clear(cnt_clear),
    .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
    .pipe_hold(pipe_hold), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .redirect_take(redirect_take), .state(state), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  hazard_unit #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .dmem_busy(dmem_busy), .cnt_clear(cnt_clear),
    .stall(s_stall), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .pipe_hold(s_pipe_hold), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .redirect_take(s_redirect_take), .state(s_state), .stall_cnt(s_stall_cnt),
    .flush_cnt(s_flush_cnt), .freeze_cnt(s_freeze_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model: mode 0=running, 1=bubble just inserted, 2=frozen
  int m_mode = 0;
  bit m_pend = 1'b0;
  int m_sc = 0, m_fc = 0, m_zc = 0;
  int ms_sc = 0, ms_fc = 0, ms_zc = 0;

  logic [6:0] ops [9] = '{LD, ST, RR, BR, IM, JR, JL, LU, AU};

  function automatic int sat_inc(input int c, input bit en, input int maxv);
    return (en && c < maxv) ? c + 1 : c;
  endfunction

  function automatic logic [6:0] model_ctl(input in_t x);
    bit u1, u2, haz;
    if (x.rst) return RSTP;
    u1  = x.op inside {LD, ST, RR, BR, IM, JR};
    u2  = x.op inside {ST, RR, BR};
    haz = x.v && x.mr && (x.rd != 0) && ((u1 && x.rs1 == x.rd) || (u2 && x.rs2 == x.rd));
    if (x.busy) return FRZ;
    if (x.redir || m_pend) return RDR;
    if (haz && m_mode != 1) return STL;
    return IDL;
  endfunction

  task automatic commit(input in_t x, input logic [6:0] c);
    if (x.rst) begin
      m_mode = 0; m_pend = 1'b0;
      m_sc = 0; m_fc = 0; m_zc = 0; ms_sc = 0; ms_fc = 0; ms_zc = 0;
      return;
    end
    if (x.clr) begin
      m_sc = 0; m_fc = 0; m_zc = 0; ms_sc = 0; ms_fc = 0; ms_zc = 0;
    end else begin
      m_sc  = sat_inc(m_sc,  c[6], 65535);
      m_fc  = sat_inc(m_fc,  c[1], 65535);
      m_zc  = sat_inc(m_zc,  c[3], 65535);
      ms_sc = sat_inc(ms_sc, c[6], 15);
      ms_fc = sat_inc(ms_fc, c[1], 15);
      ms_zc = sat_inc(ms_zc, c[3], 15);
    end
    if (x.busy) begin
      m_mode = 2;
      m_pend = m_pend | x.redir;
    end else if (x.redir || m_pend) begin
      m_mode = 0;
      m_pend = 1'b0;
    end else if (c == STL) m_mode = 1;
    else m_mode = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input in_t x);
    rst = x.rst; id_valid = x.v; id_opcode = x.op; id_rs1 = x.rs1; id_rs2 = x.rs2;
    ex_memread = x.mr; ex_rd = x.rd; ex_redirect = x.redir; dmem_busy = x.busy;
    cnt_clear = x.clr;
  endtask

  function automatic logic [6:0] dut_ctl();
    return {stall, pc_write, ifid_write, pipe_hold, ifid_flush, idex_flush, redirect_take};
  endfunction

  function automatic logic [6:0] dut_s_ctl();
    return {s_stall, s_pc_write, s_ifid_write, s_pipe_hold, s_ifid_flush, s_idex_flush, s_redirect_take};
  endfunction

  // Checks every output of both instances against the model, then clocks
  task automatic model_cycle(input in_t x);
    logic [6:0] c;
    apply(x);
    @(negedge clk);
    c = model_ctl(x);
    check("ctl", 32'(dut_ctl()), 32'(c));
    check("ctl_s", 32'(dut_s_ctl()), 32'(c));
    check("state", 32'(state), 32'(m_mode));
    check("stall_cnt", 32'(stall_cnt), 32'(m_sc));
    check("flush_cnt", 32'(flush_cnt), 32'(m_fc));
    check("freeze_cnt", 32'(freeze_cnt), 32'(m_zc));
    check("s_cnts", 32'({s_stall_cnt, s_flush_cnt, s_freeze_cnt}),
          32'({4'(ms_sc), 4'(ms_fc), 4'(ms_zc)}));
    @(posedge clk);
    commit(x, c);
    #1;
  endtask

  function automatic in_t mk_in(input logic r, input logic v, input logic [6:0] op,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic mr, input logic [4:0] rd,
                                input logic redir, input logic busy);
    in_t x;
    x.rst = r; x.v = v; x.op = op; x.rs1 = rs1; x.rs2 = rs2;
    x.mr = mr; x.rd = rd; x.redir = redir; x.busy = busy; x.clr = 1'b0;
    return x;
  endfunction

  function automatic vec_t mk(input in_t x, input logic [6:0] ctl, input logic [1:0] st,
                              input logic chk, input int sc, input int fc, input int zc);
    vec_t r;
    r.i = x; r.ctl = ctl; r.st = st; r.chk = chk; r.sc = sc; r.fc = fc; r.zc = zc;
    return r;
  endfunction

  vec_t tbl [20];

  initial begin
    in_t idle, x;
    logic [6:0] c;
    idle = mk_in(0, 0, 7'd0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = mk(mk_in(1, 0, 7'd0, 0, 0, 0, 0, 0, 0), RSTP, 2'd0, 1, 0, 0, 0);
    tbl[1]  = mk(idle, IDL, 2'd0, 1, 0, 0, 0);
    tbl[2]  = mk(mk_in(0, 1, RR, 3, 5, 1, 5, 0, 0), STL, 2'd0, 0, 0, 0, 0);
    tbl[3]  = mk(mk_in(0, 1, RR, 3, 5, 1, 5, 0, 0), IDL, 2'd1, 0, 0, 0, 0);
    tbl[4]  = mk(idle, IDL, 2'd0, 1, 1, 0, 0);
    tbl[5]  = mk(mk_in(0, 1, IM, 0, 0, 1, 0, 0, 0), IDL, 2'd0, 0, 0, 0, 0);
    tbl[6]  = mk(mk_in(0, 1, JL, 5, 0, 1, 5, 0, 0), IDL, 2'd0, 0, 0, 0, 0);
    tbl[7]  = mk(mk_in(0, 1, IM, 1, 5, 1, 5, 0, 0), IDL, 2'd0, 0, 0, 0, 0);
    tbl[8]  = mk(mk_in(0, 1, ST, 1, 5, 1, 5, 0, 0), STL, 2'd0, 0, 0, 0, 0);
    tbl[9]  = mk(idle, IDL, 2'd1, 0, 0, 0, 0);
    tbl[10] = mk(mk_in(0, 1, RR, 5, 0, 1, 5, 1, 0), RDR, 2'd0, 0, 0, 0, 0);
    tbl[11] = mk(idle, IDL, 2'd0, 1, 2, 1, 0);
    tbl[12] = mk(mk_in(0, 0, 7'd0, 0, 0, 0, 0, 0, 1), FRZ, 2'd0, 0, 0, 0, 0);
    tbl[13] = mk(mk_in(0, 0, 7'd0, 0, 0, 0, 0, 1, 1), FRZ, 2'd2, 0, 0, 0, 0);
    tbl[14] = mk(mk_in(0, 0, 7'd0, 0, 0, 0, 0, 0, 1), FRZ, 2'd2, 0, 0, 0, 0);
    tbl[15] = mk(idle, RDR, 2'd2, 0, 0, 0, 0);
    tbl[16] = mk(idle, IDL, 2'd0, 1, 2, 2, 3);
    tbl[17] = mk(mk_in(0, 0, 7'd0, 0, 0, 0, 0, 1, 1), FRZ, 2'd0, 0, 0, 0, 0);
    tbl[18] = mk(mk_in(1, 0, 7'd0, 0, 0, 0, 0, 0, 1), RSTP, 2'd2, 0, 0, 0, 0);
    tbl[19] = mk(idle, IDL, 2'd0, 1, 0, 0, 0);

    // Initial reset
    apply(mk_in(1, 0, 7'd0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;

    // Directed table with hand-derived expectations
    for (int k = 0; k < 20; k++) begin
      apply(tbl[k].i);
      @(negedge clk);
      c = model_ctl(tbl[k].i);
      check($sformatf("tbl%0d_ctl", k), 32'(dut_ctl()), 32'(tbl[k].ctl));
      check($sformatf("tbl%0d_state", k), 32'(state), 32'(tbl[k].st));
      if (tbl[k].chk)
        check($sformatf("tbl%0d_cnts", k), {8'd0, 8'(stall_cnt), 8'(flush_cnt), 8'(freeze_cnt)},
              {8'd0, 8'(tbl[k].sc), 8'(tbl[k].fc), 8'(tbl[k].zc)});
      @(posedge clk);
      commit(tbl[k].i, c);
      #1;
    end

    // Stall counter saturation on the 4-bit instance, then clear with a stall
    model_cycle(mk_in(1, 0, 7'd0, 0, 0, 0, 0, 0, 0));
    x = mk_in(0, 1, RR, 7, 0, 1, 7, 0, 0);
    for (int k = 0; k < 14; k++) begin
      model_cycle(x);
      model_cycle(x);
    end
    check("sat_pre", 32'(s_stall_cnt), 32'(4'hE));
    for (int k = 0; k < 3; k++) begin
      model_cycle(x);
      model_cycle(x);
    end
    check("sat_top", 32'(s_stall_cnt), 32'(4'hF));
    check("sat_wide", 32'(stall_cnt), 32'd17);
    x.clr = 1'b1;
    model_cycle(x);
    check("clr_small", 32'(s_stall_cnt), 32'd0);
    check("clr_wide", 32'(stall_cnt), 32'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      x.rst   = ($urandom_range(0, 79) == 0);
      x.v     = ($urandom_range(0, 7) != 0);
      x.op    = ops[$urandom_range(0, 8)];
      x.rs1   = 5'($urandom_range(0, 3));
      x.rs2   = 5'($urandom_range(0, 3));
      x.mr    = ($urandom_range(0, 1) == 1);
      x.rd    = 5'($urandom_range(0, 3));
      x.redir = ($urandom_range(0, 6) == 0);
      x.busy  = ($urandom_range(0, 4) == 0);
      x.clr   = ($urandom_range(0, 199) == 0);
      model_cycle(x);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
